// File: rtl/jk_multimode_reg.sv
// WIDTH-bit register built from per-bit JK cores. A runtime mode maps (a, b) onto J/K
// for JK, SR, D or T behaviour, with change pulse and sticky illegal-SR flags.
module jk_multimode_reg #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             chg,
  output logic [WIDTH-1:0] err_bits,
  output logic             err
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_SR = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] sr_viol;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    j       = '0;
    k       = '0;
    sr_viol = '0;
    case (mode_e'(mode))
      MODE_JK: begin
        j = a;
        k = b;
      end
      MODE_SR: begin
        // Illegal S=R=1 bits are forced to hold; legal bits update normally.
        sr_viol = a & b;
        j       = a & ~sr_viol;
        k       = b & ~sr_viol;
      end
      MODE_D: begin
        j = a;
        k = ~a;
      end
      default: begin
        j = a;
        k = a;
      end
    endcase
  end

  always_comb begin
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b00:   q_next[i] = q[i];
        2'b01:   q_next[i] = 1'b0;
        2'b10:   q_next[i] = 1'b1;
        default: q_next[i] = ~q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= RST_VAL;
      chg      <= 1'b0;
      err_bits <= '0;
    end else begin
      if (en) begin
        q   <= q_next;
        chg <= |(q_next ^ q);
      end else begin
        chg <= 1'b0;
      end
      // A fresh violation outranks err_clr in the same cycle.
      err_bits <= (en ? sr_viol : '0) | (err_clr ? '0 : err_bits);
    end
  end

  assign qb  = ~q;
  assign err = |err_bits;

endmodule

// File: tb/tb_jk_multimode_reg.sv
// Directed bench for jk_multimode_reg (WIDTH=4, RST_VAL=4'b1010) with hand-computed
// expected values for reset, D/T/JK/SR modes, enable, sticky errors and async reset.
module tb_jk_multimode_reg;

  localparam int         WIDTH   = 4;
  localparam logic [3:0] RST_VAL = 4'b1010;
  localparam logic [1:0] M_JK = 2'b00, M_SR = 2'b01, M_D = 2'b10, M_T = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       mode = M_D;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             chg;
  logic [WIDTH-1:0] err_bits;
  logic             err;

  int tests_run = 0;
  int tests_failed = 0;

  jk_multimode_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q), .qb(qb), .chg(chg), .err_bits(err_bits), .err(err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #20000;
    tests_failed++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs, then advance one edge and settle past it
  task automatic step(input logic e, input logic [1:0] m, input logic [3:0] av,
                      input logic [3:0] bv, input logic clr);
    en = e; mode = m; a = av; b = bv; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] v);
    step(1'b1, M_D, v, 4'($urandom_range(0, 15)), 1'b0);
    check("load_q", q, v);
  endtask

  initial begin
    // reset asserted between edges, no clock edge in between
    #3 rst = 1'b1;
    #1;
    check("rst_q", q, 4'b1010);
    check("rst_qb", qb, 4'b0101);
    check("rst_chg", chg, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_bits", err_bits, 4'b0000);
    en = 1'b1; a = 4'b1111;
    @(posedge clk); #1;
    check("rst_hold_q", q, 4'b1010);
    rst = 1'b0;

    // D mode; b toggles randomly and must be ignored
    load(4'b0000);
    check("d_load_chg", chg, 1'b1);
    step(1'b1, M_D, 4'b1011, 4'($urandom_range(0, 15)), 1'b0);
    check("d1_q", q, 4'b1011);  check("d1_chg", chg, 1'b1);
    step(1'b1, M_D, 4'b1011, 4'($urandom_range(0, 15)), 1'b0);
    check("d2_q", q, 4'b1011);  check("d2_chg", chg, 1'b0);
    step(1'b1, M_D, 4'b0100, 4'($urandom_range(0, 15)), 1'b0);
    check("d3_q", q, 4'b0100);  check("d3_chg", chg, 1'b1);
    check("d3_qb", qb, 4'b1011);

    // T mode from 0000, then disabled
    load(4'b0000);
    step(1'b1, M_T, 4'b0011, 4'b1010, 1'b0);
    check("t1_q", q, 4'b0011);  check("t1_chg", chg, 1'b1);
    step(1'b1, M_T, 4'b0011, 4'b0101, 1'b0);
    check("t2_q", q, 4'b0000);  check("t2_chg", chg, 1'b1);
    step(1'b1, M_T, 4'b0011, 4'b0000, 1'b0);
    check("t3_q", q, 4'b0011);  check("t3_chg", chg, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, M_T, 4'b1111, 4'b1111, 1'b0);
      check("en0_q", q, 4'b0011);
      check("en0_chg", chg, 1'b0);
    end

    // JK mode from 0101
    load(4'b0101);
    step(1'b1, M_JK, 4'b1100, 4'b0110, 1'b0);
    check("jk1_q", q, 4'b1001);  check("jk1_chg", chg, 1'b1);
    step(1'b1, M_JK, 4'b1111, 4'b1111, 1'b0);
    check("jk2_q", q, 4'b0110);
    check("jk_err", err, 1'b0);

    // SR mode from 0011 with illegal bit3
    load(4'b0011);
    step(1'b1, M_SR, 4'b1010, 4'b1001, 1'b0);
    check("sr1_q", q, 4'b0010);
    check("sr1_err_bits", err_bits, 4'b1000);
    check("sr1_err", err, 1'b1);
    step(1'b1, M_SR, 4'b0000, 4'b0000, 1'b1);
    check("sr_clr_err_bits", err_bits, 4'b0000);
    check("sr_clr_err", err, 1'b0);
    check("sr_clr_q", q, 4'b0010);
    step(1'b1, M_SR, 4'b1010, 4'b1001, 1'b1);
    check("sr_win_err_bits", err_bits, 4'b1000);
    check("sr_win_chg", chg, 1'b0);
    // disabled: no capture, but clear still honoured
    step(1'b0, M_SR, 4'b1111, 4'b1111, 1'b0);
    check("sr_en0_err_bits", err_bits, 4'b1000);
    check("sr_en0_q", q, 4'b0010);
    step(1'b0, M_SR, 4'b1111, 4'b1111, 1'b1);
    check("sr_en0_clr", err_bits, 4'b0000);
    step(1'b1, M_SR, 4'b0001, 4'b0001, 1'b0);
    check("sr_b0_err_bits", err_bits, 4'b0001);

    // async reset mid-stream while toggling; error pending
    step(1'b1, M_T, 4'b1111, 4'b0000, 1'b0);
    check("tt1_q", q, 4'b1101);
    check("tt1_err_bits", err_bits, 4'b0001);
    step(1'b1, M_T, 4'b1111, 4'b0000, 1'b0);
    check("tt2_q", q, 4'b0010);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_q", q, RST_VAL);
    check("arst_qb", qb, 4'b0101);
    check("arst_chg", chg, 1'b0);
    check("arst_err_bits", err_bits, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, M_T, 4'b1111, 4'b0000, 1'b0);
    check("post_rst_q", q, 4'b0101);
    check("post_rst_chg", chg, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jk_multimode_reg.md
Name: jk_multimode_reg

Overview:
- WIDTH-bit register. Every bit is a JK flip-flop core.
- A runtime mode select converts two generic input vectors (a, b) into per-bit J/K drive. One block implements JK, SR, D or T storage.
- Successor to the single-bit fixed-conversion flip-flops. Adds:
  - width parameterisation;
  - mode switching;
  - enable;
  - change detection;
  - sticky illegal-SR error reporting.
- Used as the general state-holding element in sequential labs and small datapaths.

Parameters:
- WIDTH, 4, number of register bits (1..32).
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  update enable. When 0, q holds.
- mode  input  2  00=JK, 01=SR, 10=D, 11=T.
- a  input  WIDTH  J / S / D / T input, by mode.
- b  input  WIDTH  K / R input. Ignored in D and T modes.
- err_clr  input  1  clears sticky error bits.
- q  output  WIDTH  register state.
- qb  output  WIDTH  ~q, combinational from q.
- chg  output  1  registered: 1 for one cycle after an enabled edge that changed any bit of q.
- err_bits  output  WIDTH  sticky per-bit illegal-SR flags.
- err  output  1  OR-reduction of err_bits (combinational).

Behaviour:
- Reset (rst=1, asynchronous, overrides everything):
  - q=RST_VAL, qb=~RST_VAL, chg=0, err_bits=0, err=0.
  - Held while rst=1.
  - The first update happens on the first rising clk edge after rst falls.
- Per-bit J/K derivation (combinational, bit i):
  - JK: J=a[i], K=b[i].
  - SR: J=a[i], K=b[i]. If a[i]=b[i]=1, the bit is illegal: force J=K=0 (hold) and flag it.
  - D: J=a[i], K=~a[i].
  - T: J=a[i], K=a[i].
- JK core next state, evaluated at the rising clk edge when en=1:
  - J=0, K=0: hold.
  - J=0, K=1: 0.
  - J=1, K=0: 1.
  - J=1, K=1: toggle.
- Latency: q reflects inputs sampled at edge N immediately after edge N. There is no pipeline.
- en=0 at an edge:
  - q holds.
  - chg<=0.
  - No error capture.
  - err_clr is still honoured.
- chg at an edge with en=1: chg <= |(q_next ^ q). It is a one-cycle pulse per changing edge and stays high on consecutive changing edges.
- err_bits[i] at each edge, in priority order:
  - set if en=1, mode=SR, a[i]=b[i]=1;
  - else cleared if err_clr=1;
  - else hold.
  - A new violation in the same cycle as err_clr wins.
- Mode change: takes effect at the same edge it is sampled. There is no state flush, and q carries over unchanged.
- Bit independence: each bit is evaluated independently. Illegal SR on one bit does not affect legal bits updating in the same cycle.
- Reset mid-operation: q, chg and err_bits clear asynchronously without waiting for clk.

Test Plan:
- Reset, WIDTH=4, RST_VAL=4'b1010: assert rst between clk edges. Required response, with no clock edge: q=1010, qb=0101, chg=0, err=0.
- D mode, en=1:
  - from q=0000, a=1011, then 1011 again, then 0100;
  - q=1011 with chg=1, then 1011 with chg=0, then 0100 with chg=1.
  - Toggling b throughout has no effect.
- T mode from q=0000: a=0011 for 3 edges gives q=0011, 0000, 0011.
- Then en=0 with a=1111 for 2 edges: q stays 0011 and chg=0.
- JK mode from q=0101:
  - a=1100, b=0110 gives q=1001 (bit3 set, bit2 toggle, bit1 reset, bit0 hold).
  - a=b=1111 gives q=0110.
- SR mode from q=0011:
  - a=1010, b=1001 gives q=0010 (bit3 illegal holds 0, bit1 set, bit0 reset), err_bits=1000, err=1.
  - Then a=b=0 with err_clr=1 gives err_bits=0000.
  - Repeating the violation with err_clr=1 in the same cycle leaves err_bits=1000.
- Async reset mid-stream: T mode toggling with a=1111. Assert rst half a cycle after an edge: q returns to RST_VAL before the next edge, and err_bits=0.
